led_flasher_multi: RTL
======================

# led_flasher_multi

Multi-channel, parametrised LED flasher for the thermometer front panel. Each channel drives a group of LEDs for a fixed, clock-derived duration when its trigger is asserted. A channel runs in solid or blink mode, can be aborted, and reports busy/done status to the controller FSM. This block replaces per-event single-flasher instances with one shared block whose channels share a clock and reset but are otherwise independent.

## Interface
- SYS_FREQ, 100000000: system clock frequency in Hz; must be a multiple of 1000.
- PERIOD_MS, 20000: flash duration in ms. FLASH_CYC = SYS_FREQ/1000*PERIOD_MS, computed at 64 bits; must satisfy 2 ≤ FLASH_CYC < 2^32.
- BLINK_MS, 250: blink half-period in ms. HALF_CYC = SYS_FREQ/1000*BLINK_MS; must satisfy 1 ≤ HALF_CYC ≤ FLASH_CYC.
- NUM_CH, 4: number of channels, 1..16.
- LED_W, 4: LEDs per channel, 1..8.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- trigger  input  NUM_CH  per-channel start request, level-sensitive, sampled at clk.
- mode  input  NUM_CH  per-channel mode: 0 = solid, 1 = blink. Latched when the channel starts.
- abort  input  NUM_CH  per-channel stop request, sampled at clk.
- led_on  output  NUM_CH*LED_W  LED drive. Channel c occupies bits [c*LED_W +: LED_W]. Registered.
- busy  output  NUM_CH  channel c is in RUN. Registered.
- done  output  NUM_CH  one-cycle pulse when a flash completes naturally. Registered.

## Operation
- Each channel has these registers: state (IDLE/RUN), a 32-bit duration counter cnt, a half-period counter hcnt, a phase bit, and a latched mode bit.
- Transitions from IDLE:
  - trigger=1 and abort=0: go to RUN with cnt=0, hcnt=0, phase=1, latch mode.
  - Otherwise: stay in IDLE.
- Transitions from RUN:
  - abort=1: go to IDLE. No done pulse. Abort has priority over everything.
  - cnt==FLASH_CYC-1: go to IDLE and pulse done.
  - Otherwise: cnt+1.
- Blink phase: hcnt counts 0..HALF_CYC-1 and then wraps. phase toggles on the wrap.
- LED outputs:
  - Solid mode: led_on group is all ones for every RUN cycle.
  - Blink mode: led_on group is all ones when phase=1, zero otherwise.
  - IDLE: led_on group is always zero.
- busy equals (state==RUN).
- Channels never interact. Simultaneous triggers on several channels start in the same cycle.
- Trigger held high keeps a channel continuously re-flashing. After each completion the channel passes through exactly one IDLE cycle, with done high and LEDs off, before restarting.
- Reset (reset=0) takes effect immediately, at any time including mid-flash. All state returns to IDLE, counters to 0, phase to 0; led_on, busy and done go to 0. Outputs stay 0 until reset deasserts.

## Timing
- Start latency: trigger sampled high at edge k gives busy=1 and LEDs driven from edge k through edge k+FLASH_CYC. That is exactly FLASH_CYC cycles in RUN.
- done is high during the single cycle after edge k+FLASH_CYC. In that same cycle busy=0 and LEDs are off.
- Abort sampled at edge j clears busy and LEDs after edge j.
- Blink: the LED group is on for HALF_CYC cycles, then off for HALF_CYC cycles, starting with on. The last half-period is truncated at FLASH_CYC.
- Mode changes during RUN are ignored until the next start.

## Configuration
- LED_FLASHER_RETRIGGER_EN
  - Defined: trigger=1 with abort=0 during RUN, including the final cycle, restarts the flash. cnt=0, hcnt=0, phase=1, mode is re-latched, and no done pulse is produced for the interrupted flash.
  - Undefined: trigger is ignored during RUN. A flash always lasts FLASH_CYC cycles unless aborted.

## Test plan
Common bench parameters: SYS_FREQ=1000, PERIOD_MS=10 (FLASH_CYC=10), BLINK_MS=2 (HALF_CYC=2), NUM_CH=2, LED_W=4.

- Solid flash: 1-cycle trigger[0] pulse, mode=0 -> led_on[3:0]=4'hF and busy[0]=1 for exactly 10 cycles, then done[0] pulses for 1 cycle. Channel 1 stays 0 throughout.
- Blink flash: trigger[1] with mode=1 -> led_on[7:4] pattern F,F,0,0,F,F,0,0,F,F over 10 cycles, then done[1]=1.
- Abort: abort[0]=1 at RUN cycle 4 -> busy[0] and LEDs go to 0 the next cycle, and done[0] never pulses.
- Retrigger: trigger[0] re-asserted at RUN cycle 6.
  - With macro: RUN lasts 6+10 cycles and produces a single done.
  - Without macro: RUN lasts 10 cycles and produces one done.
- Held trigger: trigger[0] held high for 25 cycles -> RUN 10 cycles, 1 IDLE cycle with done=1, RUN 10 cycles, 1 IDLE cycle with done=1, then RUN again.
- Asynchronous reset: reset=0 asserted mid-cycle at RUN cycle 5 -> all outputs 0 without waiting for a clk edge. After release with trigger=0, the channel stays in IDLE.

Source files
------------

// File: rtl/led_flasher_multi.sv
// led_flasher_multi: NUM_CH independent LED flashers with solid/blink mode, abort, and busy/done status.
// Optional feature macro LED_FLASHER_RETRIGGER_EN: trigger during RUN restarts the flash.
module led_flasher_multi #(
   parameter int SYS_FREQ  = 100000000,
   parameter int PERIOD_MS = 20000,
   parameter int BLINK_MS  = 250,
   parameter int NUM_CH    = 4,
   parameter int LED_W     = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       trigger,
   input  logic [NUM_CH-1:0]       mode,
   input  logic [NUM_CH-1:0]       abort,
   output logic [NUM_CH*LED_W-1:0] led_on,
   output logic [NUM_CH-1:0]       busy,
   output logic [NUM_CH-1:0]       done
);
   localparam logic [63:0] FLASH_CYC = 64'(SYS_FREQ) / 64'd1000 * 64'(PERIOD_MS);
   localparam logic [63:0] HALF_CYC  = 64'(SYS_FREQ) / 64'd1000 * 64'(BLINK_MS);
   localparam logic [31:0] CNT_LAST  = 32'(FLASH_CYC - 64'd1);
   localparam logic [31:0] HCNT_LAST = 32'(HALF_CYC - 64'd1);

   typedef enum logic {IDLE, RUN} state_t;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      state_t      state_q, state_d;
      logic [31:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
      logic        phase_q, phase_d, mode_q, mode_d, led_q, led_d, done_q, done_d;
      logic        start;

      // next state: abort beats (re)start, which beats natural completion; LED drive follows the next state
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         hcnt_d  = hcnt_q;
         phase_d = phase_q;
         mode_d  = mode_q;
         done_d  = 1'b0;
`ifdef LED_FLASHER_RETRIGGER_EN
         start   = trigger[c] && !abort[c];
`else
         start   = trigger[c] && !abort[c] && state_q == IDLE;
`endif
         if (state_q == RUN && abort[c]) begin
            state_d = IDLE;
            cnt_d   = '0;
            hcnt_d  = '0;
            phase_d = 1'b0;
         end else if (start) begin
            state_d = RUN;
            cnt_d   = '0;
            hcnt_d  = '0;
            phase_d = 1'b1;
            mode_d  = mode[c];
         end else if (state_q == RUN) begin
            if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               done_d  = 1'b1;
               cnt_d   = '0;
               hcnt_d  = '0;
               phase_d = 1'b0;
            end else begin
               cnt_d   = cnt_q + 32'd1;
               hcnt_d  = (hcnt_q == HCNT_LAST) ? '0 : hcnt_q + 32'd1;
               phase_d = (hcnt_q == HCNT_LAST) ? !phase_q : phase_q;
            end
         end
         led_d = (state_d == RUN) && (!mode_d || phase_d);
      end

      // channel registers, cleared immediately by the asynchronous reset
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hcnt_q  <= '0;
            phase_q <= 1'b0;
            mode_q  <= 1'b0;
            led_q   <= 1'b0;
            done_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hcnt_q  <= hcnt_d;
            phase_q <= phase_d;
            mode_q  <= mode_d;
            led_q   <= led_d;
            done_q  <= done_d;
         end
      end

      assign led_on[c*LED_W +: LED_W] = {LED_W{led_q}};
      assign busy[c] = (state_q == RUN);
      assign done[c] = done_q;
   end
endmodule
